// File: rtl/qsn_perm_sched.sv
// qsn_perm_sched: issues per-submatrix QSN shift factors from the layer ROM and tracks permuted-data arrival
module qsn_perm_sched #(
  parameter int CHECK_PARALLELISM = 85,
  parameter int SHIFT_WIDTH = 7,
  parameter int ADDR_WIDTH = 6,
  parameter int LEN_WIDTH = 4,
  parameter int BS_PIPELINE_LEVEL = 2,
  parameter int CTRL_LATENCY = 1
) (
  input  logic                   sys_clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  layer_base,
  input  logic [LEN_WIDTH-1:0]   layer_len,
  input  logic                   hold,
  output logic                   rom_rd_en,
  output logic [ADDR_WIDTH-1:0]  rom_addr,
  input  logic [SHIFT_WIDTH-1:0] rom_shift,
  output logic [SHIFT_WIDTH-1:0] shift_factor,
  output logic                   shift_valid,
  output logic                   perm_valid,
  output logic [LEN_WIDTH-1:0]   perm_idx,
  output logic                   busy,
  output logic                   done,
  output logic                   shift_err
);
  localparam int PERM_LATENCY = CTRL_LATENCY + BS_PIPELINE_LEVEL;
  localparam int DEPTH = 2 + PERM_LATENCY;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0] len, cnt;
  logic [DEPTH-1:0] v;
  logic [LEN_WIDTH-1:0] idx [DEPTH];
  logic rd, is_null, is_oor;
  assign rd = (state == ISSUE) && !hold;
  assign rom_rd_en = rd;
  assign rom_addr = rd ? base + ADDR_WIDTH'(cnt) : '0;
  assign is_null = rom_shift == '1;
  assign is_oor = !is_null && rom_shift >= SHIFT_WIDTH'(CHECK_PARALLELISM);
  // stage 0 tracks the outstanding ROM read; null entries drop out at stage 1
  assign shift_valid = v[1];
  assign perm_valid = v[DEPTH-1];
  assign perm_idx = perm_valid ? idx[DEPTH-1] : '0;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      base <= '0;
      len <= '0;
      cnt <= '0;
      shift_err <= 1'b0;
    end else begin
      if (v[0] && is_oor) shift_err <= 1'b1;
      case (state)
        IDLE: if (start) begin
          base <= layer_base;
          len <= layer_len;
          cnt <= '0;
          shift_err <= 1'b0;
          state <= (layer_len == '0) ? DONE : ISSUE;
        end
        ISSUE: if (!hold) begin
          cnt <= cnt + 1'b1;
          if (cnt == len - 1'b1) state <= DRAIN;
        end
        DRAIN: if (v == '0) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      v <= '0;
      shift_factor <= '0;
      idx <= '{default: '0};
    end else begin
      v <= {v[DEPTH-2:1], v[0] & ~is_null, rd};
      idx[0] <= cnt;
      for (int k = 1; k < DEPTH; k++) idx[k] <= idx[k-1];
      if (v[0] && !is_null) shift_factor <= is_oor ? '0 : rom_shift;
    end
  end
endmodule
